// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between NUM_PORTS caches; optional snoop broadcast under MEM_ARB_SNOOP_EN.
// Latency: grant and memory request one cycle after the request is sampled; response one cycle after mem_ready.
// Backpressure: one transaction at a time; other requesters wait, holding re/we high until granted and answered.
module mem_bus_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int ADDRESS_BITS = 32,
    parameter int WORDSIZE     = 32,
    parameter int WORDSPERLINE = 2
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_PORTS-1:0]                            req_re,
    input  logic [NUM_PORTS-1:0]                            req_we,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0]               req_addr,
    input  logic [NUM_PORTS*WORDSPERLINE*WORDSIZE-1:0]      req_data,
    output logic [NUM_PORTS-1:0]                            granted,
    output logic [NUM_PORTS-1:0]                            resp_ready,
    output logic [WORDSPERLINE*WORDSIZE-1:0]                resp_data,
    output logic [ADDRESS_BITS-1:0]                         snoop_addr,
    output logic [NUM_PORTS-1:0]                            snoop_we,
    output logic                                            mem_re,
    output logic                                            mem_we,
    output logic [ADDRESS_BITS-1:0]                         mem_addr,
    output logic [WORDSPERLINE*WORDSIZE-1:0]                mem_wdata,
    input  logic [WORDSPERLINE*WORDSIZE-1:0]                mem_rdata,
    input  logic                                            mem_ready
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int LB = WORDSPERLINE * WORDSIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     arb_win;
    logic              arb_any;
    logic              lat_we;
    logic [ADDRESS_BITS-1:0] lat_addr;
    logic [LB-1:0]     lat_data;
    int                idx;

    // Pick the first requesting port at or after rr_ptr, wrapping around.
    always_comb begin
        arb_any = 1'b0;
        arb_win = '0;
        idx     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!arb_any && (req_re[idx] || req_we[idx])) begin
                arb_any = 1'b1;
                arb_win = PW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-port handshake outputs.
    always_comb begin
        state_nxt  = state;
        granted    = '0;
        resp_ready = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                granted[win] = 1'b1;
                mem_re       = !lat_we;
                mem_we       = lat_we;
                if (mem_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                granted[win]    = 1'b1;
                resp_ready[win] = 1'b1;
                state_nxt       = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winning request, capture the read line, advance the round-robin pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr    <= '0;
            win       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            resp_data <= '0;
        end else begin
            if (state == ST_IDLE && arb_any) begin
                win      <= arb_win;
                lat_we   <= req_we[arb_win];
                lat_addr <= req_addr[arb_win*ADDRESS_BITS +: ADDRESS_BITS];
                lat_data <= req_data[arb_win*LB +: LB];
            end
            if (state == ST_BUSY && mem_ready) begin
                resp_data <= mem_rdata;
            end
            if (state == ST_DONE) begin
                if (win == PW'(NUM_PORTS - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= win + 1'b1;
                end
            end
        end
    end

    // Memory sees address/data only while a transaction is in flight.
    assign mem_addr  = (state == ST_BUSY) ? lat_addr : '0;
    assign mem_wdata = (state == ST_BUSY && lat_we) ? lat_data : '0;

`ifdef MEM_ARB_SNOOP_EN
    logic [NUM_PORTS-1:0] arb_onehot;

    // One-hot of the port about to be granted.
    always_comb begin
        arb_onehot          = '0;
        arb_onehot[arb_win] = 1'b1;
    end

    // Strobe every other cache for the first BUSY cycle of a write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            snoop_we   <= '0;
            snoop_addr <= '0;
        end else if (state == ST_IDLE && arb_any && req_we[arb_win]) begin
            snoop_we   <= ~arb_onehot;
            snoop_addr <= req_addr[arb_win*ADDRESS_BITS +: ADDRESS_BITS];
        end else begin
            snoop_we   <= '0;
        end
    end
`else
    assign snoop_we   = '0;
    assign snoop_addr = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a transaction-level round-robin reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Snoop expectations follow MEM_ARB_SNOOP_EN as defined for the build.
module tb_mem_bus_arbiter;
    localparam int NP  = 2;
    localparam int AB  = 32;
    localparam int WS  = 32;
    localparam int WPL = 2;
    localparam int LB  = WS * WPL;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NP-1:0]      req_re = '0;
    logic [NP-1:0]      req_we = '0;
    logic [NP*AB-1:0]   req_addr = '0;
    logic [NP*LB-1:0]   req_data = '0;
    logic [NP-1:0]      granted;
    logic [NP-1:0]      resp_ready;
    logic [LB-1:0]      resp_data;
    logic [AB-1:0]      snoop_addr;
    logic [NP-1:0]      snoop_we;
    logic               mem_re;
    logic               mem_we;
    logic [AB-1:0]      mem_addr;
    logic [LB-1:0]      mem_wdata;
    logic [LB-1:0]      mem_rdata = '0;
    logic               mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int m_rr = 0;
    logic [LB-1:0] m_last_resp = '0;

    mem_bus_arbiter #(
        .NUM_PORTS(NP), .ADDRESS_BITS(AB), .WORDSIZE(WS), .WORDSPERLINE(WPL)
    ) dut (
        .clock(clock), .reset(reset),
        .req_re(req_re), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .granted(granted), .resp_ready(resp_ready), .resp_data(resp_data),
        .snoop_addr(snoop_addr), .snoop_we(snoop_we),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [LB-1:0] rand_line();
        return {$urandom, $urandom};
    endfunction

    task automatic set_port(input int p, input logic re, input logic we,
                            input logic [AB-1:0] a, input logic [LB-1:0] d);
        req_re[p]          = re;
        req_we[p]          = we;
        req_addr[p*AB +: AB] = a;
        req_data[p*LB +: LB] = d;
    endtask

    task automatic clear_reqs;
        req_re = '0;
        req_we = '0;
    endtask

    task automatic do_reset;
        clear_reqs();
        mem_ready = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset       = 1'b1;
        m_rr        = 0;
        m_last_resp = '0;
    endtask

    // Runs one transaction from an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    task automatic run_txn(input int delay, input logic [LB-1:0] rdata, input string tag);
        int            win;
        logic          op_we;
        logic [AB-1:0] a;
        logic [LB-1:0] d;
        logic [NP-1:0] exp_snoop;
        logic [NP-1:0] exp_g;
        win = -1;
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (win < 0 && (req_re[p] || req_we[p])) win = p;
        end
        if (win < 0) begin
            checks++; errors++;
            $display("FAIL %s no request driven by bench", tag);
            return;
        end
        op_we = req_we[win];
        a     = req_addr[win*AB +: AB];
        d     = req_data[win*LB +: LB];
        exp_g = onehot(win);
`ifdef MEM_ARB_SNOOP_EN
        exp_snoop = op_we ? ~exp_g : '0;
`else
        exp_snoop = '0;
`endif
        tick();
        for (int k = 0; k <= delay; k++) begin
            checks++; if (granted !== exp_g) begin errors++; $display("FAIL %s busy%0d granted got %b want %b", tag, k, granted, exp_g); end
            checks++; if (mem_re !== !op_we) begin errors++; $display("FAIL %s busy%0d mem_re got %b want %b", tag, k, mem_re, !op_we); end
            checks++; if (mem_we !== op_we) begin errors++; $display("FAIL %s busy%0d mem_we got %b want %b", tag, k, mem_we, op_we); end
            checks++; if (mem_addr !== a) begin errors++; $display("FAIL %s busy%0d mem_addr got %h want %h", tag, k, mem_addr, a); end
            checks++; if (resp_ready !== '0) begin errors++; $display("FAIL %s busy%0d resp_ready got %b want 0", tag, k, resp_ready); end
            if (op_we) begin
                checks++; if (mem_wdata !== d) begin errors++; $display("FAIL %s busy%0d mem_wdata got %h want %h", tag, k, mem_wdata, d); end
            end
            checks++;
            if (snoop_we !== ((k == 0) ? exp_snoop : '0)) begin
                errors++; $display("FAIL %s busy%0d snoop_we got %b want %b", tag, k, snoop_we, (k == 0) ? exp_snoop : '0);
            end
            if (k == 0 && exp_snoop != '0) begin
                checks++; if (snoop_addr !== a) begin errors++; $display("FAIL %s snoop_addr got %h want %h", tag, snoop_addr, a); end
            end
`ifndef MEM_ARB_SNOOP_EN
            checks++; if (snoop_addr !== '0) begin errors++; $display("FAIL %s snoop_addr got %h want 0", tag, snoop_addr); end
`endif
            // Scramble request payloads while busy: the latched values must be used.
            for (int p = 0; p < NP; p++) begin
                req_addr[p*AB +: AB] = $urandom;
                req_data[p*LB +: LB] = rand_line();
            end
            mem_ready = (k == delay);
            mem_rdata = (k == delay) ? rdata : rand_line();
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = rand_line();
        checks++; if (granted !== exp_g) begin errors++; $display("FAIL %s done granted got %b want %b", tag, granted, exp_g); end
        checks++; if (resp_ready !== exp_g) begin errors++; $display("FAIL %s done resp_ready got %b want %b", tag, resp_ready, exp_g); end
        checks++; if (resp_data !== rdata) begin errors++; $display("FAIL %s done resp_data got %h want %h", tag, resp_data, rdata); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL %s done mem_re/we got %b%b want 00", tag, mem_re, mem_we); end
        checks++; if (snoop_we !== '0) begin errors++; $display("FAIL %s done snoop_we got %b want 0", tag, snoop_we); end
        req_re[win] = 1'b0;
        req_we[win] = 1'b0;
        m_rr        = (win + 1) % NP;
        m_last_resp = rdata;
        tick();
        checks++; if (granted !== '0) begin errors++; $display("FAIL %s idle granted got %b want 0", tag, granted); end
        checks++; if (resp_ready !== '0) begin errors++; $display("FAIL %s idle resp_ready got %b want 0", tag, resp_ready); end
        checks++; if (resp_data !== rdata) begin errors++; $display("FAIL %s idle resp_data got %h want %h", tag, resp_data, rdata); end
    endtask

    task automatic test_reset;
        clear_reqs();
        reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 32'h0000_0010, 64'h1111_2222_3333_4444);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({granted, resp_ready, resp_data, snoop_addr, snoop_we, mem_re, mem_we, mem_addr, mem_wdata} !== '0) begin
                errors++;
                $display("FAIL reset cycle%0d outputs not zero: granted %b resp_ready %b resp_data %h snoop_we %b snoop_addr %h mem_re %b mem_we %b mem_addr %h mem_wdata %h",
                         c, granted, resp_ready, resp_data, snoop_we, snoop_addr, mem_re, mem_we, mem_addr, mem_wdata);
            end
        end
        reset = 1'b1;
        m_rr  = 0;
        run_txn(1, 64'hDEAD_BEEF_0123_4567, "reset_release");
    endtask

    task automatic test_read_port1;
        clear_reqs();
        set_port(1, 1'b1, 1'b0, 32'h0000_0008, rand_line());
        run_txn(2, {32'h7000_0083, 32'hEF00_0013}, "read_p1");
    endtask

    task automatic test_round_robin;
        do_reset();
        set_port(0, 1'b1, 1'b0, 32'h0000_0100, rand_line());
        set_port(1, 1'b1, 1'b0, 32'h0000_0200, rand_line());
        run_txn(0, rand_line(), "rr_first");
        set_port(0, 1'b1, 1'b0, 32'h0000_0104, rand_line());
        run_txn(1, rand_line(), "rr_second");
        set_port(1, 1'b1, 1'b0, 32'h0000_0204, rand_line());
        run_txn(0, rand_line(), "rr_third");
        clear_reqs();
    endtask

    task automatic test_write_snoop;
        clear_reqs();
        set_port(0, 1'b0, 1'b1, 32'h0000_0004, {32'h0000_0000, 32'h0000_0330});
        run_txn(0, rand_line(), "write_p0");
        set_port(1, 1'b1, 1'b0, 32'h0000_0004, rand_line());
        run_txn(1, rand_line(), "read_nosnoop");
        set_port(1, 1'b1, 1'b1, 32'h0000_00C0, rand_line());
        run_txn(2, rand_line(), "rewe_p1");
    endtask

    task automatic test_mem_ready_ignored;
        clear_reqs();
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            mem_rdata = rand_line();
            tick();
            checks++; if (resp_ready !== '0) begin errors++; $display("FAIL ready_ignored cycle%0d resp_ready got %b want 0", c, resp_ready); end
            checks++; if (granted !== '0) begin errors++; $display("FAIL ready_ignored cycle%0d granted got %b want 0", c, granted); end
            checks++; if (resp_data !== m_last_resp) begin errors++; $display("FAIL ready_ignored cycle%0d resp_data got %h want %h", c, resp_data, m_last_resp); end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_busy;
        clear_reqs();
        set_port(1, 1'b1, 1'b0, 32'h0000_0040, rand_line());
        tick();
        checks++; if (granted !== 2'b10) begin errors++; $display("FAIL reset_busy granted got %b want 10", granted); end
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL reset_busy mem_re got %b want 1", mem_re); end
        reset = 1'b0;
        clear_reqs();
        tick();
        checks++; if ({granted, mem_re, mem_we} !== '0) begin errors++; $display("FAIL reset_busy after reset granted %b mem_re %b mem_we %b want zeros", granted, mem_re, mem_we); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL reset_busy resp_data got %h want 0", resp_data); end
        reset       = 1'b1;
        m_rr        = 0;
        m_last_resp = '0;
        mem_ready   = 1'b1;
        mem_rdata   = rand_line();
        tick();
        mem_ready = 1'b0;
        checks++; if (resp_ready !== '0) begin errors++; $display("FAIL reset_busy late ready resp_ready got %b want 0", resp_ready); end
        tick();
        checks++; if (resp_ready !== '0) begin errors++; $display("FAIL reset_busy late ready+1 resp_ready got %b want 0", resp_ready); end
        checks++; if (granted !== '0) begin errors++; $display("FAIL reset_busy late ready+1 granted got %b want 0", granted); end
    endtask

    task automatic test_random;
        clear_reqs();
        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!(req_re[p] || req_we[p]) && $urandom_range(0, 1) == 1) begin
                    int op;
                    op = $urandom_range(0, 2);
                    set_port(p, op != 1, op != 0, $urandom, rand_line());
                end
            end
            if ((req_re | req_we) == '0) begin
                set_port($urandom_range(0, NP - 1), 1'b1, 1'b0, $urandom, rand_line());
            end
            run_txn($urandom_range(0, 3), rand_line(), "random");
        end
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_read_port1();
        test_round_robin();
        test_write_snoop();
        test_mem_ready_ignored();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares the single main-memory line port between `NUM_PORTS` L1 cache wrappers (I-cache, D-cache, or per-core caches). It sits between each cache's `cache2mem_*`/`mem2cache_*` interface and the main memory. It drives each cache's `granted` input. It broadcasts `snoop_addr`/`snoop_we` so that the other caches invalidate lines another requester writes back.

## Interface
- `NUM_PORTS`, 2: number of cache requesters (≥2).
- `ADDRESS_BITS`, 32: address width.
- `WORDSIZE`, 32: bits per word.
- `WORDSPERLINE`, 2: words per cache line.
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `req_re` in [NUM_PORTS]: per-port `cache2mem_re`.
- `req_we` in [NUM_PORTS]: per-port `cache2mem_we`.
- `req_addr` in [NUM_PORTS][ADDRESS_BITS]: per-port `cache2mem_addr`.
- `req_data` in [NUM_PORTS][WORDSPERLINE][WORDSIZE]: per-port `cache2mem_data`.
- `granted` out [NUM_PORTS]: one-hot ownership of the memory port.
- `resp_ready` out [NUM_PORTS]: per-port `mem2cache_ready`.
- `resp_data` out [WORDSPERLINE][WORDSIZE]: shared `mem2cache_data`, valid only with `resp_ready`.
- `snoop_addr` out ADDRESS_BITS: broadcast write address.
- `snoop_we` out [NUM_PORTS]: per-port snoop strobe.
- `mem_re`, `mem_we` out 1: requests to main memory.
- `mem_addr` out ADDRESS_BITS: address to main memory.
- `mem_wdata` out [WORDSPERLINE][WORDSIZE]: write line to main memory.
- `mem_rdata` in [WORDSPERLINE][WORDSIZE]: read line from main memory.
- `mem_ready` in 1: main memory done; one-cycle pulse.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - A port is requesting when `req_re|req_we` is high.
  - Winner: the first requesting port at or after `rr_ptr`, wrapping modulo NUM_PORTS.
  - Latch the winner index, `req_addr`, `req_data` and op. If `req_we` is high the op is a write; `re&we` counts as a write.
  - Go to BUSY.
- BUSY:
  - `granted[win]`=1.
  - `mem_re`/`mem_we` driven from the latched op, with `mem_addr`/`mem_wdata` from the latched values.
  - On `mem_ready`, capture `mem_rdata` into `resp_data` and go to DONE.
- DONE:
  - `resp_ready[win]`=1 for exactly one cycle, `granted[win]` still 1, memory requests low.
  - `rr_ptr` ← (win+1) mod NUM_PORTS.
  - Go to IDLE.
- Requester duty: deassert `re`/`we` in the cycle `resp_ready` is seen. A request still high in the following IDLE cycle is treated as a new request.
- Request changes during BUSY are ignored because the values are latched.
- Only the granted port's `resp_ready` ever asserts; `resp_data` holds its value until the next capture.
- Snoop: on entry to BUSY with a write op, `snoop_addr`=latched address and `snoop_we[j]`=1 for every j≠win, for exactly the first BUSY cycle. `snoop_we[win]` is never asserted.
- Reset (low at an edge, in any state):
  - State → IDLE, `rr_ptr`=0.
  - All outputs 0, including `resp_data` and `snoop_addr`.
  - An in-flight memory access is abandoned; the memory sees `mem_re`/`mem_we` drop on the next cycle.

## Timing
- A request sampled at edge T gives `granted` and `mem_re`/`mem_we` high in cycle T+1.
- `mem_ready` high in cycle M gives `resp_ready` and `resp_data` in cycle M+1, and `granted` drops in cycle M+2.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUSY, DONE) with memory ready in the first BUSY cycle.
- Back-to-back requests from different ports have a 1-cycle IDLE gap between grants.
- `mem_ready` is ignored outside BUSY.
- Simultaneous requests from all ports are served in round-robin order starting at `rr_ptr`. No port waits more than NUM_PORTS−1 transactions.

## Configuration
- `MEM_ARB_SNOOP_EN` defined: snoop broadcast as above.
- Not defined: `snoop_we` tied to 0 and `snoop_addr` tied to 0; no snoop logic is synthesized. All arbitration behaviour is unchanged.

## Test plan
- Reset with `reset`=0 for 4 cycles while port 0 requests: every output is 0. Release reset: `granted`=2'b01 one cycle later.
- Port 1 reads 0x08, memory returns {0x70000083, 0xEF000013}, `mem_ready` a 2-cycle delay later: `mem_re`=1 and `mem_addr`=0x08 during BUSY. `resp_ready[1]` pulses once with that data. Port 0's `resp_ready` stays 0.
- Both ports request in the same cycle after reset: port 0 is served first, then port 1. With both still requesting, the third grant goes to port 0.
- Port 0 writes 0x04 with line {0x0, 0x330} (`MEM_ARB_SNOOP_EN` defined): `snoop_we`=2'b10 and `snoop_addr`=0x04 for exactly 1 cycle. `mem_wdata` matches. No snoop on reads.
- `reset` driven low during BUSY: in the next cycle state is IDLE with `granted`, `mem_re` and `mem_we` at 0, and a late `mem_ready` produces no `resp_ready`.
- Build without `MEM_ARB_SNOOP_EN` and repeat the write test: `snoop_we` stays 0 and the transaction timing is identical.
